// File: rtl/max7219_pkg.sv
// max7219_pkg
// Shared constants for the MAX7219 display driver: register addresses,
// Code-B character codes, the sequencer state encoding and the serialiser
// phase encoding.
package max7219_pkg;

  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam logic [3:0] CODEB_DASH  = 4'hA;
  localparam logic [3:0] CODEB_E     = 4'hB;
  localparam logic [3:0] CODEB_H     = 4'hC;
  localparam logic [3:0] CODEB_L     = 4'hD;
  localparam logic [3:0] CODEB_P     = 4'hE;
  localparam logic [3:0] CODEB_BLANK = 4'hF;

  // Number of configuration words sent before the first refresh.
  localparam int INIT_WORDS = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_NEXT,
    ST_IDLE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LOW,
    PH_HIGH,
    PH_TAIL
  } phase_t;

endpackage

// File: rtl/max7219_shift.sv
// max7219_shift
// 16-bit MSB-first serialiser for the MAX7219 3-wire interface.
// A load pulse (accepted only while idle) captures data and drops cs on the
// next clock. Each bit is CLK_DIV clocks with sck low followed by CLK_DIV
// clocks with sck high; din changes only when sck falls. After the 16th
// high phase sck stays low for CLK_DIV more clocks, then cs rises and done
// pulses for one clock.
// Ports:
//   clock, reset  system clock, synchronous active-low reset
//   load          one-cycle start request
//   data[15:0]    frame to send
//   sck, din, cs  serial interface (cs active-low)
//   done          one-cycle pulse, coincident with cs rising
module max7219_shift
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  output logic        sck,
  output logic        din,
  output logic        cs,
  output logic        done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  phase_t        phase_q, phase_d;
  logic [DW-1:0] div_q;
  logic [3:0]    bit_q;
  logic [15:0]   shreg_q;
  logic          tick;

  always_comb begin
    phase_d = phase_q;
    tick    = (div_q == '0);
    case (phase_q)
      PH_IDLE: if (load) phase_d = PH_LOW;
      PH_LOW:  if (tick) phase_d = PH_HIGH;
      PH_HIGH: if (tick) phase_d = (bit_q == 4'd0) ? PH_TAIL : PH_LOW;
      PH_TAIL: if (tick) phase_d = PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      div_q   <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 16'h0000;
      sck     <= 1'b0;
      din     <= 1'b0;
      cs      <= 1'b1;
      done    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      done    <= 1'b0;
      case (phase_q)
        PH_IDLE: begin
          if (load) begin
            shreg_q <= data;
            din     <= data[15];
            cs      <= 1'b0;
            div_q   <= DIV_MAX;
            bit_q   <= 4'd15;
          end
        end
        PH_LOW: begin
          if (tick) begin
            sck   <= 1'b1;
            div_q <= DIV_MAX;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        PH_HIGH: begin
          if (tick) begin
            sck   <= 1'b0;
            div_q <= DIV_MAX;
            if (bit_q != 4'd0) begin
              shreg_q <= {shreg_q[14:0], 1'b0};
              din     <= shreg_q[14];
              bit_q   <= bit_q - 1'b1;
            end
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        PH_TAIL: begin
          if (tick) begin
            cs   <= 1'b1;
            done <= 1'b1;
          end else begin
            div_q <= div_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/max7219_driver.sv
// max7219_driver
// Display stage: sends the MAX7219 init words after reset, one refresh
// from the reset-value snapshot, then a refresh on every latch. A latch
// while busy is held as a single pending request (last one wins).
//
// state | meaning
// INIT  | select the next init word (entered after reset and between init words)
// LOAD  | start the serialiser on the selected word (cs falls next clock)
// SHIFT | 16 bits in flight, wait for the serialiser done pulse
// GAP   | cs high for 2*CLK_DIV clocks
// NEXT  | advance the word index, chain a new refresh, or go idle
// IDLE  | waiting for latch
//
// Frame timing: LOAD to next LOAD is 35*CLK_DIV+3 clocks within a refresh
// (one more for init words, which pass through INIT). cs is high for
// 2*CLK_DIV+3 clocks between frames. Latch in IDLE drops cs 2 clocks later.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   latch             capture the inputs below and refresh
//   mode              0: show num, 1: show code on every digit
//   dp[2:0]           decimal-point digit index (0 = LSD)
//   code[3:0]         Code-B character for mode 1
//   num               BCD value, nibble 0 = LSD
//   brightness[3:0]   intensity 0..15
//   sck, din, cs      MAX7219 serial interface
//   busy              init/refresh in progress or pending
module max7219_driver
  import max7219_pkg::*;
#(
  parameter int DIGIT_NUM = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   latch,
  input  logic                   mode,
  input  logic [2:0]             dp,
  input  logic [3:0]             code,
  input  logic [DIGIT_NUM*4-1:0] num,
  input  logic [3:0]             brightness,
  output logic                   sck,
  output logic                   din,
  output logic                   cs,
  output logic                   busy
);

  localparam int GW = $clog2(2 * CLK_DIV);
  localparam logic [GW-1:0] GAP_MAX = GW'(2 * CLK_DIV - 1);
  // Word index: 0..3 init words, then digits, then intensity.
  localparam logic [3:0] FIRST_DIGIT = 4'(INIT_WORDS);
  localparam logic [3:0] LAST_IDX    = 4'(INIT_WORDS + DIGIT_NUM);

  state_t        state_q, state_d;
  logic [3:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic          pending_q;

  logic                   mode_q, pend_mode;
  logic [2:0]             dp_q, pend_dp;
  logic [3:0]             code_q, pend_code;
  logic [DIGIT_NUM*4-1:0] num_q, pend_num;
  logic [3:0]             bright_q, pend_bright;

  logic        shift_load, shift_done;
  logic        take_latch, take_pend, idx_step, idx_restart, gap_start;
  logic [15:0] word;
  logic [2:0]  dig;
  logic [3:0]  nib;
  logic        upper_nz, blank;
  logic [7:0]  digit_data;

  always_comb begin
    state_d     = state_q;
    shift_load  = 1'b0;
    take_latch  = 1'b0;
    take_pend   = 1'b0;
    idx_step    = 1'b0;
    idx_restart = 1'b0;
    gap_start   = 1'b0;
    case (state_q)
      ST_INIT:  state_d = ST_LOAD;
      ST_LOAD: begin
        shift_load = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          gap_start = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP:   if (gap_q == '0) state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          // A latch arriving right now is newer than anything pending.
          if (latch) begin
            take_latch  = 1'b1;
            idx_restart = 1'b1;
            state_d     = ST_LOAD;
          end else if (pending_q) begin
            take_pend   = 1'b1;
            idx_restart = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_step = 1'b1;
          state_d  = (idx_q < FIRST_DIGIT - 4'd1) ? ST_INIT : ST_LOAD;
        end
      end
      ST_IDLE: begin
        if (latch) begin
          take_latch  = 1'b1;
          idx_restart = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      idx_q       <= 4'd0;
      gap_q       <= '0;
      pending_q   <= 1'b0;
      mode_q      <= 1'b0;
      dp_q        <= 3'd0;
      code_q      <= 4'd0;
      num_q       <= '0;
      bright_q    <= 4'd0;
      pend_mode   <= 1'b0;
      pend_dp     <= 3'd0;
      pend_code   <= 4'd0;
      pend_num    <= '0;
      pend_bright <= 4'd0;
    end else begin
      state_q <= state_d;

      if (gap_start)          gap_q <= GAP_MAX;
      else if (gap_q != '0)   gap_q <= gap_q - 1'b1;

      if (idx_restart)        idx_q <= FIRST_DIGIT;
      else if (idx_step)      idx_q <= idx_q + 4'd1;

      if (take_latch) begin
        mode_q   <= mode;
        dp_q     <= dp;
        code_q   <= code;
        num_q    <= num;
        bright_q <= brightness;
      end else if (take_pend) begin
        mode_q   <= pend_mode;
        dp_q     <= pend_dp;
        code_q   <= pend_code;
        num_q    <= pend_num;
        bright_q <= pend_bright;
      end

      if (latch && !take_latch) begin
        pending_q   <= 1'b1;
        pend_mode   <= mode;
        pend_dp     <= dp;
        pend_code   <= code;
        pend_num    <= num;
        pend_bright <= brightness;
      end else if (take_latch || take_pend) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Digit byte for the current word index. A zero is blanked only when no
  // nonzero nibble sits at or above it and it is above both dp and digit 0.
  always_comb begin
    dig      = 3'(idx_q - FIRST_DIGIT);
    nib      = 4'h0;
    upper_nz = 1'b0;
    for (int j = 0; j < DIGIT_NUM; j++) begin
      if (j == int'(dig)) nib = num_q[j*4 +: 4];
      if (j >= int'(dig) && num_q[j*4 +: 4] != 4'h0) upper_nz = 1'b1;
    end
    blank      = !upper_nz && (dig > dp_q) && (dig != 3'd0);
    digit_data = 8'h00;
    if (mode_q) digit_data = {4'h0, code_q};
    else        digit_data = {(dig == dp_q), 3'b000, blank ? CODEB_BLANK : nib};
  end

  always_comb begin
    word = 16'h0000;
    case (idx_q)
      4'd0:    word = {4'h0, ADDR_TEST, 8'h00};
      4'd1:    word = {4'h0, ADDR_SCANLIMIT, 8'(DIGIT_NUM - 1)};
      4'd2:    word = {4'h0, ADDR_DECODE, 8'hFF};
      4'd3:    word = {4'h0, ADDR_SHUTDOWN, 8'h01};
      default: begin
        if (idx_q == LAST_IDX) word = {4'h0, ADDR_INTENSITY, 4'h0, bright_q};
        else                   word = {4'h0, {1'b0, dig} + 4'd1, digit_data};
      end
    endcase
  end

  max7219_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clock (clock),
    .reset (reset),
    .load  (shift_load),
    .data  (word),
    .sck   (sck),
    .din   (din),
    .cs    (cs),
    .done  (shift_done)
  );

  assign busy = (state_q != ST_IDLE) || pending_q;

endmodule

// File: tb/tb_max7219_driver.sv
// tb_max7219_driver
// Scoreboard bench: stimulus pushes hand-computed frames into exp_q, an SPI
// monitor decodes every completed frame and compares it against the queue,
// and also checks sck period, din stability and the cs-high gap.
module tb_max7219_driver;

  localparam int DN = 8;
  localparam int CD = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          latch;
  logic          mode;
  logic [2:0]    dp;
  logic [3:0]    code;
  logic [DN*4-1:0] num;
  logic [3:0]    brightness;
  logic          sck, din, cs, busy;

  int tests  = 0;
  int failed = 0;
  logic [15:0] exp_q[$];

  always #5 clock = ~clock;

  max7219_driver #(.DIGIT_NUM(DN), .CLK_DIV(CD)) dut (
    .clock      (clock),
    .reset      (reset),
    .latch      (latch),
    .mode       (mode),
    .dp         (dp),
    .code       (code),
    .num        (num),
    .brightness (brightness),
    .sck        (sck),
    .din        (din),
    .cs         (cs),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // digits: byte i = data byte for digit i (digit 0 in [7:0])
  task automatic push_refresh(input logic [63:0] digits, input logic [3:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back({4'h0, 4'(i + 1), digits[i*8 +: 8]});
    exp_q.push_back({8'h0A, 4'h0, b});
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0C01);
    push_refresh(64'h0F0F0F0F_0F0F0F80, 4'h0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Latch from IDLE and check the 2-clock latch-to-cs-fall latency.
  task automatic latch_idle(input string name);
    latch = 1'b1;
    @(posedge clock); #1;
    latch = 1'b0;
    check({name, "_cs_still_high"}, cs, 1'b1);
    @(posedge clock); #1;
    check({name, "_latch_to_cs"}, cs, 1'b0);
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    @(posedge clock); #1;
    latch = 1'b0;
  endtask

  task automatic wait_sck_rises(input int n, input int budget);
    int cnt = 0;
    int c = 0;
    logic prev = sck;
    while (cnt < n && c < budget) begin
      @(posedge clock); #1;
      c++;
      if (!prev && sck) cnt++;
      prev = sck;
    end
    check("sck_rise_wait", cnt, n);
  endtask

  // SPI monitor
  logic        m_prev_cs = 1'b1, m_prev_sck = 1'b0, m_prev_din = 1'b0;
  logic        m_in_frame = 1'b0, m_first_rise = 1'b1, m_seen_end = 1'b0;
  logic [15:0] m_shreg = 16'h0;
  int          m_nbits = 0, m_cyc = 0, m_last_rise = 0, m_end_cyc = 0;
  logic [15:0] m_exp;

  always @(negedge clock) begin
    m_cyc++;
    if (!reset) begin
      m_in_frame = 1'b0;
      m_nbits    = 0;
      m_seen_end = 1'b0;
    end else begin
      if (m_prev_cs && !cs) begin
        if (m_seen_end) check("cs_gap_ge_2div", (m_cyc - m_end_cyc) >= 2 * CD, 1'b1);
        m_in_frame   = 1'b1;
        m_nbits      = 0;
        m_first_rise = 1'b1;
      end
      if (!m_prev_sck && sck) begin
        check("sck_rise_in_frame", cs, 1'b0);
        check("din_stable_rise", din, m_prev_din);
        if (!m_first_rise) check("sck_period", m_cyc - m_last_rise, 2 * CD);
        m_first_rise = 1'b0;
        m_last_rise  = m_cyc;
        m_shreg      = {m_shreg[14:0], din};
        m_nbits++;
      end else if (m_prev_sck && sck && din !== m_prev_din) begin
        check("din_hold_high", din, m_prev_din);
      end
      if (!m_prev_cs && cs && m_in_frame) begin
        m_in_frame = 1'b0;
        m_seen_end = 1'b1;
        m_end_cyc  = m_cyc;
        check("frame_bits", m_nbits, 16);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", m_shreg, 16'hxxxx);
        end else begin
          m_exp = exp_q.pop_front();
          check("frame", m_shreg, m_exp);
        end
      end
    end
    m_prev_cs  = cs;
    m_prev_sck = sck;
    m_prev_din = din;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; latch = 1'b0; mode = 1'b0; dp = 3'd0; code = 4'h0;
    num = '0; brightness = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sck", sck, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_din", din, 1'b0);
    check("rst_busy", busy, 1'b1);

    push_init();
    reset = 1'b1;
    @(posedge clock); #1;
    check("busy_in_init", busy, 1'b1);
    wait_idle("init", 3000);

    // 1234, dp on digit 2; inputs change after the latch and must be ignored
    num = 32'h0000_1234; dp = 3'd2; brightness = 4'h6; mode = 1'b0;
    push_refresh(64'h0F0F0F0F_01820304, 4'h6);
    latch_idle("r1234");
    num = 32'h9999_9999; dp = 3'd7; brightness = 4'hF;
    wait_idle("r1234", 2000);

    // mode 1: every digit shows code E, DP off
    mode = 1'b1; code = 4'hB; brightness = 4'h6; num = 32'h0000_1234; dp = 3'd2;
    push_refresh(64'h0B0B0B0B_0B0B0B0B, 4'h6);
    latch_idle("mode1");
    wait_idle("mode1", 2000);

    // interior zeros below the highest nonzero digit are not blanked
    mode = 1'b0; num = 32'h0010_0000; dp = 3'd0; brightness = 4'h3;
    push_refresh(64'h0F0F0100_00000080, 4'h3);
    latch_idle("blank_hi");
    wait_idle("blank_hi", 2000);

    // zero value: digits up to dp stay lit, above dp blank
    num = 32'h0; dp = 3'd3; brightness = 4'hF;
    push_refresh(64'h0F0F0F0F_80000000, 4'hF);
    latch_idle("blank_dp");
    wait_idle("blank_dp", 2000);

    // two latches while busy: only the last one runs, once
    num = 32'h9; dp = 3'd0; brightness = 4'h6;
    push_refresh(64'h0F0F0F0F_0F0F0F89, 4'h6);
    push_refresh(64'h0F0F0F0F_0F0F0F82, 4'h6);
    latch_idle("pend_a");
    num = 32'h1;
    pulse_latch();
    repeat (5) @(posedge clock);
    #1;
    num = 32'h2;
    pulse_latch();
    num = 32'h7;
    wait_idle("pend", 3000);

    // reset during bit 7 of the first digit frame
    num = 32'h1234; dp = 3'd2;
    push_refresh(64'h0F0F0F0F_01820304, 4'h6);
    latch_idle("mid_rst");
    wait_sck_rises(9, 200);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clock); #1;
    check("midrst_cs", cs, 1'b1);
    check("midrst_sck", sck, 1'b0);
    check("midrst_din", din, 1'b0);
    check("midrst_busy", busy, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    push_init();
    reset = 1'b1;
    wait_idle("reinit", 3000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
